pwm_generator_verilog: RTL and testbench



---
 rtl/pwm_generator_verilog.sv | 122 ++++++++++++
 tb/tb_pwm_generator_verilog.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/pwm_generator_verilog.sv
// Breathing-LED PWM: free-running counter compared against a triangle-ramped duty with holds.
// Define BREATHE_GAMMA_EN to square the duty (duty*duty >> PWM_WIDTH) for perceptual linearity.
module pwm_generator_verilog #(
  parameter int PWM_WIDTH    = 8,
  parameter int SLOW_PERIODS = 4,
  parameter int FAST_PERIODS = 1,
  parameter int HOLD_STEPS   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic speed_ctrl,
  output logic led_out
);

  localparam int PER_MAX   = (SLOW_PERIODS > FAST_PERIODS) ? SLOW_PERIODS : FAST_PERIODS;
  localparam int PER_W     = $clog2(PER_MAX + 1);
  localparam int HOLD_W    = (HOLD_STEPS > 0) ? $clog2(HOLD_STEPS + 1) : 1;
  localparam int HOLD_LAST = (HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0;

  localparam logic [PWM_WIDTH-1:0] MAX      = '1;
  localparam logic [PWM_WIDTH-1:0] DUTY_ONE = PWM_WIDTH'(1);
  localparam logic [PER_W-1:0]     PER_ONE  = PER_W'(1);
  localparam logic [HOLD_W-1:0]    HOLD_ONE = HOLD_W'(1);

  typedef enum logic [1:0] {RISE, HOLD_TOP, FALL, HOLD_BOT} state_t;

  state_t               state_q, state_d;
  logic [PWM_WIDTH-1:0] pwmCnt_q;
  logic [PWM_WIDTH-1:0] duty_q, duty_d;
  logic [PER_W-1:0]     periodCnt_q, periodCnt_d;
  logic [HOLD_W-1:0]    holdCnt_q, holdCnt_d;
  logic [1:0]           speedSync_q;
  logic                 ledOut_q;

  logic                 periodEnd;
  logic                 stepTick;
  logic [PER_W-1:0]     limitM1;
  logic [PWM_WIDTH-1:0] dutyEff;

  assign periodEnd = (pwmCnt_q == MAX);
  assign limitM1   = speedSync_q[1] ? PER_W'(FAST_PERIODS - 1) : PER_W'(SLOW_PERIODS - 1);
  // Using >= lets a switch to a shorter limit tick at the very next period end.
  assign stepTick  = periodEnd && (periodCnt_q >= limitM1);

`ifdef BREATHE_GAMMA_EN
  logic [2*PWM_WIDTH-1:0] dutySq;
  assign dutySq  = {{PWM_WIDTH{1'b0}}, duty_q} * {{PWM_WIDTH{1'b0}}, duty_q};
  assign dutyEff = dutySq[2*PWM_WIDTH-1:PWM_WIDTH];
`else
  assign dutyEff = duty_q;
`endif

  always_comb begin
    periodCnt_d = periodCnt_q;
    if (periodEnd) begin
      periodCnt_d = stepTick ? '0 : periodCnt_q + PER_ONE;
    end
  end

  // Duty only moves on a step tick, which coincides with the counter wrap.
  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    holdCnt_d = holdCnt_q;
    if (stepTick) begin
      case (state_q)
        RISE: begin
          duty_d = duty_q + DUTY_ONE;
          if (duty_q == MAX - DUTY_ONE) begin
            state_d = (HOLD_STEPS == 0) ? FALL : HOLD_TOP;
          end
        end
        HOLD_TOP: begin
          if (holdCnt_q == HOLD_W'(HOLD_LAST)) begin
            holdCnt_d = '0;
            state_d   = FALL;
          end else begin
            holdCnt_d = holdCnt_q + HOLD_ONE;
          end
        end
        FALL: begin
          duty_d = duty_q - DUTY_ONE;
          if (duty_q == DUTY_ONE) begin
            state_d = (HOLD_STEPS == 0) ? RISE : HOLD_BOT;
          end
        end
        HOLD_BOT: begin
          if (holdCnt_q == HOLD_W'(HOLD_LAST)) begin
            holdCnt_d = '0;
            state_d   = RISE;
          end else begin
            holdCnt_d = holdCnt_q + HOLD_ONE;
          end
        end
        default: state_d = RISE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RISE;
      pwmCnt_q    <= '0;
      duty_q      <= '0;
      periodCnt_q <= '0;
      holdCnt_q   <= '0;
      speedSync_q <= '0;
      ledOut_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwmCnt_q    <= pwmCnt_q + DUTY_ONE;
      duty_q      <= duty_d;
      periodCnt_q <= periodCnt_d;
      holdCnt_q   <= holdCnt_d;
      speedSync_q <= {speedSync_q[0], speed_ctrl};
      ledOut_q    <= (pwmCnt_q < dutyEff);
    end
  end

  assign led_out = ledOut_q;

endmodule

// File: tb/tb_pwm_generator_verilog.sv
// Randomised bench for pwm_generator_verilog: compares led_out and duty every cycle
// against a model that derives duty from the number of step ticks since reset.
module tb_pwm_generator_verilog;

  localparam int W      = 4;
  localparam int SLOW   = 4;
  localparam int FAST   = 1;
  localparam int HOLD   = 2;
  localparam int MAXV   = (1 << W) - 1;
  localparam int PERIOD = 1 << W;
  localparam int BREATH = 2 * MAXV + 2 * HOLD;

  logic clk;
  logic rst;
  logic speed_ctrl;
  logic led_out;

  int vectors;
  int miscompares;

  int cntM;
  int pcM;
  int kM;
  int s1M;
  int s2M;
  int ledM;

  pwm_generator_verilog #(
    .PWM_WIDTH   (W),
    .SLOW_PERIODS(SLOW),
    .FAST_PERIODS(FAST),
    .HOLD_STEPS  (HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .speed_ctrl(speed_ctrl),
    .led_out   (led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Triangle with holds, indexed by step ticks since reset.
  function automatic int dutyOf(input int k);
    int p;
    p = k % BREATH;
    if (p <= MAXV) return p;
    if (p <= MAXV + HOLD) return MAXV;
    if (p <= 2 * MAXV + HOLD) return MAXV - (p - MAXV - HOLD);
    return 0;
  endfunction

  function automatic bit fallingAt(input int k);
    int p;
    p = k % BREATH;
    return (p > MAXV + HOLD) && (p <= 2 * MAXV + HOLD);
  endfunction

  function automatic int effOf(input int d);
`ifdef BREATHE_GAMMA_EN
    return (d * d) >> W;
`else
    return d;
`endif
  endfunction

  task automatic checkOutput(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    cntM = 0; pcM = 0; kM = 0; s1M = 0; s2M = 0; ledM = 0;
  endtask

  // One rising edge of the reference: period accounting, tick, registered compare.
  task automatic modelClock(input int spd);
    int lim;
    bit tick;
    lim  = (s2M != 0) ? FAST : SLOW;
    tick = (cntM == MAXV) && (pcM >= lim - 1);
    if (cntM == MAXV) pcM = tick ? 0 : pcM + 1;
    ledM = (cntM < effOf(dutyOf(kM))) ? 1 : 0;
    if (tick) kM++;
    cntM = (cntM + 1) % PERIOD;
    s2M  = s1M;
    s1M  = spd;
  endtask

  task automatic applyStimulus(input logic spd, input logic rstIn);
    checkOutput("led_out", int'(led_out), ledM);
    checkOutput("duty", int'(dut.duty_q), dutyOf(kM));
    speed_ctrl = spd;
    rst        = rstIn;
    if (rstIn) modelReset();
    @(posedge clk);
    if (!rstIn) modelClock(int'(spd));
    @(negedge clk);
  endtask

  initial begin
    bit found;
    logic spd;
    int len;
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    speed_ctrl  = 1'b0;
    modelReset();
    @(negedge clk);

    for (int i = 0; i < 103; i++) applyStimulus(1'b0, 1'b1);

    for (int i = 0; i < 2300; i++) applyStimulus(1'b0, 1'b0);

    for (int i = 0; i < 150; i++) applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 600; i++) applyStimulus(1'b1, 1'b0);

    for (int seg = 0; seg < 20; seg++) begin
      spd = 1'($urandom % 2);
      len = int'($urandom_range(10, 300));
      if (($urandom % 8) == 0) begin
        for (int r = 0; r < int'($urandom_range(1, 3)); r++) applyStimulus(spd, 1'b1);
      end
      for (int i = 0; i < len; i++) applyStimulus(spd, 1'b0);
    end

    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (dutyOf(kM) == 7 && fallingAt(kM)) found = 1'b1;
      else applyStimulus(1'b1, 1'b0);
    end
    checkOutput("seek_fall7", int'(found), 1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("post_reset_led", int'(led_out), 0);
    for (int i = 0; i < 600; i++) applyStimulus(1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
